// File: rtl/decoder_scan.sv
// N-to-2^N active-low registered decoder with G1/G2A/G2B gating, address latch and auto-scan sequencer.
// Optional macro SCAN_LIMIT_EN adds limit_i to cap the scan range at outputs 0..limit_i.
module decoder_scan #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [SEL_W-1:0]      a_i,
  input  logic                  g1_i,
  input  logic                  g2a_i,
  input  logic                  g2b_i,
  input  logic                  gl_i,
  input  logic                  scan_i,
  input  logic [DWELL_W-1:0]    dwell_i,
`ifdef SCAN_LIMIT_EN
  input  logic [SEL_W-1:0]      limit_i,
`endif
  output logic [2**SEL_W-1:0]   y_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  wrap_o
);

  localparam int unsigned NOUT = 2**SEL_W;

  typedef enum logic [1:0] {
    ST_DIRECT,
    ST_DWELL,
    ST_BLANK
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   latch_q, latch_d;
  logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NOUT-1:0]    y_q, y_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               wrap_q, wrap_d;

  logic               en;
  logic [SEL_W-1:0]   dir_sel;
  logic [SEL_W-1:0]   last_idx;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [NOUT-1:0] dec_low(input logic [SEL_W-1:0] s);
    logic [NOUT-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return ~(one << s);
  endfunction

  assign en      = g1_i & ~g2a_i & ~g2b_i;
  assign dir_sel = gl_i ? latch_q : a_i;

`ifdef SCAN_LIMIT_EN
  assign last_idx = limit_i;
`else
  assign last_idx = '1;
`endif

  assign next_idx = (scan_idx_q >= last_idx) ? '0 : scan_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    scan_idx_d = scan_idx_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    sel_d      = sel_q;
    wrap_d     = 1'b0;

    // scan_i low overrides every scan transition, including mid-dwell
    if (!scan_i) begin
      state_d    = ST_DIRECT;
      scan_idx_d = '0;
      if (!gl_i) latch_d = a_i;
      y_d        = en ? dec_low(dir_sel) : '1;
      sel_d      = dir_sel;
    end else begin
      unique case (state_q)
        ST_DIRECT: begin
          state_d    = ST_DWELL;
          scan_idx_d = '0;
          cnt_d      = dwell_i;
          y_d        = en ? dec_low('0) : '1;
          sel_d      = '0;
        end
        ST_DWELL: begin
          if (!en) begin
            y_d = '1;
          end else if (cnt_q == '0) begin
            state_d = ST_BLANK;
            y_d     = '1;
            // wrap flag is shown during the blank cycle that precedes index 0
            wrap_d  = (scan_idx_q >= last_idx);
          end else begin
            cnt_d = cnt_q - 1'b1;
            y_d   = dec_low(scan_idx_q);
          end
        end
        ST_BLANK: begin
          if (!en) begin
            y_d = '1;
          end else begin
            state_d    = ST_DWELL;
            scan_idx_d = next_idx;
            cnt_d      = dwell_i;
            y_d        = dec_low(next_idx);
            sel_d      = next_idx;
          end
        end
        default: begin
          state_d = ST_DIRECT;
          y_d     = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_DIRECT;
      latch_q    <= '0;
      scan_idx_q <= '0;
      cnt_q      <= '0;
      y_q        <= '1;
      sel_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      latch_q    <= latch_d;
      scan_idx_q <= scan_idx_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      sel_q      <= sel_d;
      wrap_q     <= wrap_d;
    end
  end

  assign y_o    = y_q;
  assign idx_o  = sel_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: stimulus pushes model predictions, negedge monitor pops and compares.
module tb_decoder_scan;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] a;
  logic       g1, g2a, g2b, gl, scan;
  logic [7:0] dwell;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;
`ifdef SCAN_LIMIT_EN
  logic [2:0] limit;
`endif

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a),
    .g1_i    (g1),
    .g2a_i   (g2a),
    .g2b_i   (g2b),
    .gl_i    (gl),
    .scan_i  (scan),
    .dwell_i (dwell),
`ifdef SCAN_LIMIT_EN
    .limit_i (limit),
`endif
    .y_o     (y),
    .idx_o   (idx),
    .wrap_o  (wrap)
  );

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference model: position within the current scan step, counted upward.
  bit m_scan;
  int m_idx, m_t, m_d, m_latch, m_idxo;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    m_scan  = 0;
    m_idx   = 0;
    m_t     = 0;
    m_d     = 0;
    m_latch = 0;
    m_idxo  = 0;
  endfunction

  function automatic void model_push();
    exp_t e;
    bit   en;
    int   last;
    en = g1 && !g2a && !g2b;
`ifdef SCAN_LIMIT_EN
    last = int'(limit);
`else
    last = 7;
`endif
    e.wrap = 1'b0;
    if (!scan) begin
      m_scan = 0;
      m_idx  = 0;
      if (!gl) m_latch = int'(a);
      m_idxo = m_latch;
      e.y    = en ? ~(8'd1 << m_latch) : 8'hFF;
    end else if (!m_scan) begin
      m_scan = 1;
      m_idx  = 0;
      m_t    = 0;
      m_d    = int'(dwell);
      m_idxo = 0;
      e.y    = en ? 8'hFE : 8'hFF;
    end else if (!en) begin
      e.y = 8'hFF;
    end else begin
      m_t++;
      if (m_t <= m_d) begin
        e.y = ~(8'd1 << m_idx);
      end else if (m_t == m_d + 1) begin
        e.y    = 8'hFF;
        e.wrap = (m_idx >= last);
      end else begin
        m_idx  = (m_idx >= last) ? 0 : m_idx + 1;
        m_t    = 0;
        m_d    = int'(dwell);
        m_idxo = m_idx;
        e.y    = ~(8'd1 << m_idx);
      end
    end
    e.idx = 3'(m_idxo);
    q.push_back(e);
  endfunction

  task automatic cyc();
    model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("rst_y", y, 8'hFF);
    chk("rst_idx", idx, 0);
    chk("rst_wrap", wrap, 0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("y", y, e.y);
      chk("idx", idx, e.idx);
      chk("wrap", wrap, e.wrap);
      chk("at_most_one_low", ($countones(~y) <= 1), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst = 1'b1; a = '0; g1 = 1'b1; g2a = 1'b0; g2b = 1'b0;
    gl = 1'b0; scan = 1'b0; dwell = 8'd0;
`ifdef SCAN_LIMIT_EN
    limit = 3'd7;
`endif
    do_reset();

    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      cyc();
    end

    a = 3'd5;
    for (int c = 0; c < 8; c++) begin
      if (c != 4) begin
        {g1, g2a, g2b} = 3'(c);
        cyc();
      end
    end
    {g1, g2a, g2b} = 3'b100;

    a = 3'd3; gl = 1'b0; cyc();
    gl = 1'b1; a = 3'd6;
    repeat (3) cyc();
    gl = 1'b0;
    repeat (2) cyc();

    dwell = 8'd2; scan = 1'b1;
    repeat (40) cyc();

    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_scan && m_idx == 4 && m_t == 1) found = 1;
      else cyc();
    end
    chk("reach_idx4", found, 1);
    g2a = 1'b1;
    repeat (5) cyc();
    g2a = 1'b0;
    cyc();
    a = 3'd1; gl = 1'b0; scan = 1'b0;
    repeat (2) cyc();

    scan = 1'b1; dwell = 8'd1;
    repeat (6) cyc();
    do_reset();
    scan = 1'b0;
    repeat (2) cyc();

`ifdef SCAN_LIMIT_EN
    scan = 1'b0; limit = 3'd2; dwell = 8'd0;
    cyc();
    scan = 1'b1;
    repeat (24) cyc();
    scan = 1'b0; limit = 3'd7;
    cyc();
`endif

    for (int i = 0; i < 400; i++) begin
      if (($urandom % 40) == 0) scan = ~scan;
      g1    = ($urandom % 8) != 0;
      g2a   = ($urandom % 10) == 0;
      g2b   = ($urandom % 10) == 0;
      a     = 3'($urandom);
      gl    = 1'($urandom);
      dwell = 8'($urandom % 4);
`ifdef SCAN_LIMIT_EN
      if (($urandom % 20) == 0) limit = 3'($urandom);
`endif
      if (i == 200) do_reset();
      cyc();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
